unpacker_arb: RTL
=================

# unpacker_arb

Round-robin packet arbiter that shares one unpacker input port among NUM_REQ packet sources. It sits directly upstream of the unpacker and forwards whole packets (sop..eop) from one source at a time, using the unpacker `ready` as the downstream handshake. It also polices input protocol: bad vbc, a missing sop, or a stalled source. Any of these is reported through error pulses and counters.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYC, 64: consecutive idle cycles of the locked requester before the lock is forcibly released, 1..255.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_val  in  NUM_REQ  per-requester beat valid.
- req_sop  in  NUM_REQ  per-requester start of packet.
- req_eop  in  NUM_REQ  per-requester end of packet.
- req_vbc  in  NUM_REQ*8  per-requester valid byte count; slice i is [8i+7:8i].
- req_data  in  NUM_REQ*1280  per-requester 160-byte beat; slice i is [1280i+1279:1280i].
- req_ack  out  NUM_REQ  beat consumed (forwarded or dropped) this cycle.
- dn_val, dn_sop, dn_eop  out  1 each  to unpacker val/sop/eop.
- dn_vbc  out  8  to unpacker vbc.
- dn_data  out  1280  to unpacker data.
- dn_ready  in  1  unpacker ready.
- grant  out  NUM_REQ  one-hot owner of the lock; all zero when idle.
- err_vbc, err_nosop, err_timeout  out  1 each  single-cycle error pulses.
- pkt_cnt  out  16  packets forwarded (eop beats accepted); wraps.
- drop_cnt  out  16  beats dropped; wraps.

## Operation
- FSM has two states, IDLE and LOCK. The registers are state, grant, rr_ptr (log2 NUM_REQ), idle_cnt (8), pkt_cnt, and drop_cnt.
- **IDLE:**
  - Candidates are requesters with req_val & req_sop. The winner is the first candidate at or after rr_ptr, in increasing index order with wrap.
  - If a winner exists, the next state is LOCK, grant becomes onehot(winner), and rr_ptr becomes winner+1 mod NUM_REQ.
  - In this state dn_val=0 and no req_ack is given to candidates.
  - Stray beats (req_val without req_sop) are flushed one per cycle, lowest index first: req_ack=1 for that requester, drop_cnt++, err_nosop pulse. This happens in the same cycle as the winner selection.
- **LOCK:**
  - The dn_* signals are a combinational mux of the granted requester's inputs. Only the granted req_ack can assert: req_ack = req_val & dn_ready for a good beat.
  - A good beat has 1 ≤ vbc ≤ 160. Good beats are forwarded unchanged; the transfer happens when dn_val & dn_ready.
  - A bad-vbc beat (vbc 0 or >160) is not forwarded (dn_val=0). It is acked the same cycle regardless of dn_ready, with drop_cnt++ and an err_vbc pulse. If it carries eop, the lock is released as below and pkt_cnt does not increment.
  - A sop on the granted requester mid-packet is forwarded as-is; no error is raised.
  - When a good eop beat is accepted: pkt_cnt++, next state IDLE, grant cleared.
  - idle_cnt increments on each LOCK cycle with req_val=0 for the granted requester and clears when it is 1. When idle_cnt reaches TIMEOUT_CYC-1 with val still low: next state IDLE, grant cleared, err_timeout pulse, idle_cnt cleared. No eop is synthesized downstream.
- Non-granted requesters are never acked in LOCK.
- Reset has priority over everything and works mid-packet.
- Reset values:
  - state IDLE, grant 0, rr_ptr 0, idle_cnt 0, pkt_cnt 0, drop_cnt 0.
  - All err_* 0, req_ack 0.
  - dn_val/dn_sop/dn_eop 0, dn_vbc 0, dn_data 0.

## Timing
- Arbitration latency:
  - A request sampled in IDLE at cycle N gives grant at N+1.
  - The first dn_val=1 is at N+1, provided req_val holds.
- Packet gap: eop accepted at cycle M, state IDLE at M+1, next grant at M+2. Minimum one dead cycle between packets.
- req_ack and dn_* are combinational from the registered grant and current inputs. There is no pipeline register on data.
- dn_ready low stalls: req_ack=0 and the beat must be held by the requester.
- Error pulses are high exactly one cycle, in the cycle of the offending beat or expiry.
- Counters update on the cycle after the qualifying event (registered).

## Test plan
- Reset released, req0 sends a 1-beat packet (sop=eop=1, vbc=100) with dn_ready=1. Expect: grant=0001 at N+1, dn_vbc=100, dn_eop=1, req_ack[0]=1 at N+1, pkt_cnt=1, back in IDLE at N+2.
- All 4 requesters hold 1-beat packets continuously from rr_ptr=0. Expect: grants in order 0,1,2,3,0 on cycles 1,3,5,7,9; pkt_cnt=5 after cycle 9.
- req2 sends a 3-beat packet (vbc 160,160,40) while dn_ready toggles 1,0,1,0,… Expect: data forwarded unchanged, req_ack only in dn_ready cycles, no other grant until eop, pkt_cnt+1.
- req1 sends sop with vbc=0, then an eop beat with vbc=200. Expect: both acked without dn_val, err_vbc pulses twice, drop_cnt=2, pkt_cnt unchanged, return to IDLE.
- In IDLE, req3 presents val without sop. Expect: req_ack[3]=1 that cycle, err_nosop=1, drop_cnt+1, no grant.
- req0 sends sop (not eop) then drops val, with TIMEOUT_CYC=4. Expect: err_timeout on the 4th idle cycle, grant=0 next cycle. A reset asserted mid-packet in a repeat run must give grant=0, dn_val=0, and counters=0 the next cycle.

Source files
------------

// File: rtl/unpacker_arb.sv
// Round-robin packet arbiter in front of the unpacker: locks one source per packet,
// forwards good beats combinationally, drops bad-vbc / stray beats, releases stalled locks.
module unpacker_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_val,
  input  logic [NUM_REQ-1:0]        req_sop,
  input  logic [NUM_REQ-1:0]        req_eop,
  input  logic [NUM_REQ*8-1:0]      req_vbc,
  input  logic [NUM_REQ*1280-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      dn_val,
  output logic                      dn_sop,
  output logic                      dn_eop,
  output logic [7:0]                dn_vbc,
  output logic [1279:0]             dn_data,
  input  logic                      dn_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      err_vbc,
  output logic                      err_nosop,
  output logic                      err_timeout,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [7:0]         idle_cnt, idle_cnt_nxt;
  logic               pkt_inc, drop_inc;

  logic               sel_val, sel_sop, sel_eop, good;
  logic [7:0]         sel_vbc;
  logic [1279:0]      sel_data;

  logic               found, stray;
  logic [PTR_W-1:0]   win_idx;
  int unsigned        cand, win_nxt;

  // One-hot grant lets the mux be a plain AND-OR; zero grant yields all-zero beat.
  always_comb begin
    sel_val  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_vbc  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel_val  = sel_val  | (req_val[i] & grant[i]);
      sel_sop  = sel_sop  | (req_sop[i] & grant[i]);
      sel_eop  = sel_eop  | (req_eop[i] & grant[i]);
      sel_vbc  = sel_vbc  | (req_vbc[8*i +: 8] & {8{grant[i]}});
      sel_data = sel_data | (req_data[1280*i +: 1280] & {1280{grant[i]}});
    end
    good = (sel_vbc != 8'd0) && (sel_vbc <= 8'd160);
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    idle_cnt_nxt = idle_cnt;
    req_ack      = '0;
    dn_val       = 1'b0;
    dn_sop       = 1'b0;
    dn_eop       = 1'b0;
    dn_vbc       = '0;
    dn_data      = '0;
    err_vbc      = 1'b0;
    err_nosop    = 1'b0;
    err_timeout  = 1'b0;
    pkt_inc      = 1'b0;
    drop_inc     = 1'b0;
    found        = 1'b0;
    stray        = 1'b0;
    win_idx      = '0;
    cand         = 0;
    win_nxt      = 0;

    if (!reset) begin
      if (state == IDLE) begin
        idle_cnt_nxt = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          cand = 32'(rr_ptr) + k;
          if (cand >= NUM_REQ) cand = cand - NUM_REQ;
          if (!found && req_val[cand] && req_sop[cand]) begin
            found   = 1'b1;
            win_idx = PTR_W'(cand);
          end
        end
        if (found) begin
          win_nxt = 32'(win_idx) + 1;
          if (win_nxt >= NUM_REQ) win_nxt = 0;
          state_nxt          = LOCK;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          rr_ptr_nxt         = PTR_W'(win_nxt);
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!stray && req_val[i] && !req_sop[i]) begin
            stray      = 1'b1;
            req_ack[i] = 1'b1;
          end
        end
        err_nosop = stray;
        drop_inc  = stray;
      end else begin
        dn_sop  = sel_sop;
        dn_eop  = sel_eop;
        dn_vbc  = sel_vbc;
        dn_data = sel_data;
        dn_val  = sel_val & good;
        if (sel_val) begin
          idle_cnt_nxt = '0;
          if (good) begin
            if (dn_ready) begin
              req_ack = grant;
              if (sel_eop) begin
                pkt_inc   = 1'b1;
                state_nxt = IDLE;
                grant_nxt = '0;
              end
            end
          end else begin
            // Bad-vbc beats are consumed without waiting on the unpacker.
            req_ack  = grant;
            drop_inc = 1'b1;
            err_vbc  = 1'b1;
            if (sel_eop) begin
              state_nxt = IDLE;
              grant_nxt = '0;
            end
          end
        end else if (idle_cnt == 8'(TIMEOUT_CYC - 1)) begin
          err_timeout  = 1'b1;
          state_nxt    = IDLE;
          grant_nxt    = '0;
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      idle_cnt <= idle_cnt_nxt;
      if (pkt_inc)  pkt_cnt  <= pkt_cnt + 16'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
